// File: rtl/rfifo_out_stage_if.sv
// Read-side stream bundle between the FIFO read logic, the output stage and the consumer.
// master = output stage view; slave = the FIFO/consumer environment view.
interface rfifo_out_stage_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 3
);
    localparam int unsigned LVL_W = $clog2(BUF_DEPTH + 1);

    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_ready;
    logic [LVL_W-1:0]      rlevel;

    modport master (
        input  rempty, rdata, rd_ready,
        output rinc, rd_valid, rd_data, rlevel
    );

    modport slave (
        output rempty, rdata, rd_ready,
        input  rinc, rd_valid, rd_data, rlevel
    );
endinterface

// File: rtl/rfifo_out_stage.sv
// FIFO read-side output stage: credit-based pop generation, capture of the registered
// memory read, and a small circular prefetch buffer presented as a valid/ready stream.
module rfifo_out_stage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 3
) (
    input  logic                rclk,
    input  logic                rrst,
    rfifo_out_stage_if.master   bus
);
    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic                  inflight;

    logic                  rinc_c;
    logic                  push_c;
    logic                  pop_c;
    logic [CNT_W:0]        committed_c;

    // Wrap explicitly so non-power-of-2 depths index correctly.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Credit check counts the word still in flight from the memory, so the buffer never overflows.
    always_comb begin
        committed_c = {1'b0, count} + (CNT_W + 1)'(inflight);
        rinc_c      = ~rrst & ~bus.rempty & (committed_c < (CNT_W + 1)'(BUF_DEPTH));
        push_c      = inflight;
        pop_c       = (count != '0) & bus.rd_ready;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rinc_c;
            if (push_c) tail <= idx_inc(tail);
            if (pop_c)  head <= idx_inc(head);
            case ({push_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; a word in flight during reset is dropped.
    always_ff @(posedge rclk) begin
        if (push_c && !rrst) mem[tail] <= bus.rdata;
    end

    assign bus.rinc     = rinc_c;
    assign bus.rd_valid = (count != '0);
    assign bus.rd_data  = mem[head];
    assign bus.rlevel   = count;
endmodule

// File: tb/tb_rfifo_out_stage.sv
// Directed bench for rfifo_out_stage: reset, single word, streaming, backpressure, reset mid-flight.
// A behavioural FIFO source supplies rdata one clock after each pop.
module tb_rfifo_out_stage;
    logic rclk = 1'b0;
    logic rrst;

    rfifo_out_stage_if #(.DATA_WIDTH(8), .BUF_DEPTH(3)) bus ();

    rfifo_out_stage #(.DATA_WIDTH(8), .BUF_DEPTH(3)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus)
    );

    always #5 rclk = ~rclk;

    // Source model: words are src_base + pop index, read data registered one clock after the pop.
    int         src_popped = 0;
    int         src_limit;
    logic [7:0] src_base;

    assign bus.rempty = (src_popped >= src_limit);

    always @(posedge rclk) begin
        if (bus.rinc) begin
            bus.rdata  <= 8'(int'(src_base) + src_popped);
            src_popped <= src_popped + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge rclk);
        @(negedge rclk);
    endtask

    initial begin
        rrst         = 1'b1;
        bus.rd_ready = 1'b1;
        src_limit    = 1;
        src_base     = 8'hA5;

        // Reset held two clocks with a non-empty FIFO
        @(negedge rclk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_rinc",   32'(bus.rinc),     32'd0);
            chk("rst_valid",  32'(bus.rd_valid), 32'd0);
            chk("rst_level",  32'(bus.rlevel),   32'd0);
            if (i == 0) tick();
        end
        rrst = 1'b0;
        #1;
        chk("rel_rinc", 32'(bus.rinc), 32'd1);

        // Single word 0xA5 popped in cycle 0
        tick();
        chk("single_c1_rinc",  32'(bus.rinc),     32'd0);
        chk("single_c1_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        chk("single_c2_valid", 32'(bus.rd_valid), 32'd1);
        chk("single_c2_data",  32'(bus.rd_data),  32'hA5);
        chk("single_c2_level", 32'(bus.rlevel),   32'd1);
        tick();
        chk("single_c3_valid", 32'(bus.rd_valid), 32'd0);

        // Stream 0..99 at full rate
        src_base  = 8'(0 - src_popped);
        src_limit = src_popped + 100;
        #1;
        chk("stream_c0_rinc", 32'(bus.rinc), 32'd1);
        tick();
        chk("stream_c1_valid", 32'(bus.rd_valid), 32'd0);
        chk("stream_c1_rinc",  32'(bus.rinc),     32'd1);
        tick();
        for (int i = 0; i < 100; i++) begin
            chk("stream_valid", 32'(bus.rd_valid), 32'd1);
            chk("stream_data",  32'(bus.rd_data),  32'(i));
            chk("stream_rinc",  32'(bus.rinc),     (i + 2 < 100) ? 32'd1 : 32'd0);
            chk("stream_lvl_bound", 32'(bus.rlevel <= 2'd3), 32'd1);
            tick();
        end
        chk("stream_end_valid", 32'(bus.rd_valid), 32'd0);

        // Backpressure: exactly three pops, then hold, then drain
        bus.rd_ready = 1'b0;
        src_base     = 8'(8'h10 - src_popped);
        src_limit    = src_popped + 10;
        #1;
        chk("bp_c0_rinc", 32'(bus.rinc), 32'd1);
        tick();
        chk("bp_c1_rinc", 32'(bus.rinc), 32'd1);
        tick();
        chk("bp_c2_rinc", 32'(bus.rinc), 32'd1);
        tick();
        chk("bp_c3_rinc", 32'(bus.rinc), 32'd0);
        tick();
        chk("bp_c4_rinc",  32'(bus.rinc),     32'd0);
        chk("bp_c4_level", 32'(bus.rlevel),   32'd3);
        chk("bp_c4_valid", 32'(bus.rd_valid), 32'd1);
        chk("bp_c4_data",  32'(bus.rd_data),  32'h10);
        tick();
        chk("bp_c5_rinc",  32'(bus.rinc),    32'd0);
        chk("bp_c5_data",  32'(bus.rd_data), 32'h10);
        chk("bp_c5_level", 32'(bus.rlevel),  32'd3);
        bus.rd_ready = 1'b1;
        tick();
        chk("bp_c6_data",  32'(bus.rd_data), 32'h11);
        chk("bp_c6_rinc",  32'(bus.rinc),    32'd1);
        chk("bp_c6_level", 32'(bus.rlevel),  32'd2);
        tick();
        chk("bp_c7_data",  32'(bus.rd_data), 32'h12);
        chk("bp_c7_level", 32'(bus.rlevel),  32'd1);
        tick();
        chk("bp_c8_data",  32'(bus.rd_data), 32'h13);
        chk("bp_c8_level", 32'(bus.rlevel),  32'd1);
        // FIFO goes empty while a word is still in flight; that word must still arrive
        src_limit = src_popped;
        #1;
        chk("bp_c8_rinc", 32'(bus.rinc), 32'd0);
        tick();
        chk("bp_c9_valid", 32'(bus.rd_valid), 32'd1);
        chk("bp_c9_data",  32'(bus.rd_data),  32'h14);
        chk("bp_c9_rinc",  32'(bus.rinc),     32'd0);
        tick();
        chk("bp_c10_valid", 32'(bus.rd_valid), 32'd0);
        chk("bp_c10_level", 32'(bus.rlevel),   32'd0);

        // Reset while a word is in flight: it must be discarded
        src_base  = 8'(8'h50 - src_popped);
        src_limit = src_popped + 1;
        #1;
        chk("rf_c0_rinc", 32'(bus.rinc), 32'd1);
        tick();
        rrst = 1'b1;
        #1;
        chk("rf_c1_rinc", 32'(bus.rinc), 32'd0);
        tick();
        rrst = 1'b0;
        #1;
        chk("rf_after_valid", 32'(bus.rd_valid), 32'd0);
        chk("rf_after_level", 32'(bus.rlevel),   32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rf_no_ghost", 32'(bus.rd_valid), 32'd0);
        end

        // Next word after the reset is 0x51, not the dropped 0x50
        src_limit = src_popped + 1;
        #1;
        chk("rf_next_rinc", 32'(bus.rinc), 32'd1);
        tick();
        tick();
        chk("rf_next_valid", 32'(bus.rd_valid), 32'd1);
        chk("rf_next_data",  32'(bus.rd_data),  32'h51);
        tick();
        chk("rf_next_drained", 32'(bus.rd_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
